// File: rtl/glyph_rom_arbiter.sv
// Two-requester arbiter in front of a shared, one-cycle-latency glyph ROM.
// Define GLYPH_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module glyph_rom_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [5:0]  code0,
   input  logic [5:0]  code1,
   output logic        ack0,
   output logic        ack1,
   output logic [55:0] glyph,
   output logic        unk,
   output logic [5:0]  rom_code,
   input  logic [7:0]  rom_col0,
   input  logic [7:0]  rom_col1,
   input  logic [7:0]  rom_col2,
   input  logic [7:0]  rom_col3,
   input  logic [7:0]  rom_col4,
   input  logic [7:0]  rom_col5,
   input  logic [7:0]  rom_col6,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [5:0] SPACE_CODE = 6'h3E;
   localparam logic [5:0] UNK_LO     = 6'h25;
   localparam logic [5:0] UNK_HI     = 6'h3D;

   state_t      state_reg;
   logic        winner_reg;
   logic        any_req;
   logic        grant1;
   logic [7:0]  col_arr [7];
   logic [55:0] rom_cols;

   assign any_req = req0 | req1;

   assign col_arr[0] = rom_col0;
   assign col_arr[1] = rom_col1;
   assign col_arr[2] = rom_col2;
   assign col_arr[3] = rom_col3;
   assign col_arr[4] = rom_col4;
   assign col_arr[5] = rom_col5;
   assign col_arr[6] = rom_col6;

   genvar gi;
   generate
      for (gi = 0; gi < 7; gi++) begin : g_cols
         assign rom_cols[gi*8 +: 8] = col_arr[gi];
      end
   endgenerate

`ifdef GLYPH_ARB_RR_EN
   // last_grant_reg holds the ID granted most recently; resetting it to 1 favours requester 0.
   logic last_grant_reg;

   assign grant1 = req1 & (~req0 | ~last_grant_reg);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_reg <= 1'b1;
      end else if (state_reg == IDLE && any_req) begin
         last_grant_reg <= grant1;
      end
   end
`else
   assign grant1 = req1 & ~req0;
`endif

   // ack is registered on the RESP->IDLE edge, so it is seen in the cycle after edge k+3.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         winner_reg <= 1'b0;
         rom_code   <= SPACE_CODE;
         glyph      <= '0;
         unk        <= 1'b0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (any_req) begin
                  winner_reg <= grant1;
                  rom_code   <= grant1 ? code1 : code0;
                  state_reg  <= ISSUE;
                  busy       <= 1'b1;
               end
            end
            ISSUE: begin
               state_reg <= WAIT;
            end
            WAIT: begin
               glyph     <= rom_cols;
               unk       <= (rom_code >= UNK_LO) && (rom_code <= UNK_HI);
               state_reg <= RESP;
            end
            RESP: begin
               ack0      <= ~winner_reg;
               ack1      <= winner_reg;
               state_reg <= IDLE;
               busy      <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// Bench for glyph_rom_arbiter: directed scenarios plus random traffic against a
// transaction-timing reference model; the glyph ROM is emulated here.
module tb_glyph_rom_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1;
   logic [5:0]  code0, code1;
   logic        ack0, ack1, unk, busy;
   logic [55:0] glyph;
   logic [5:0]  rom_code;
   logic [55:0] rom_q;

   int nerr = 0;
   int nchk = 0;

   // reference model state
   logic        m_infl;
   int          m_age;
   logic        m_win;
   logic [5:0]  m_code;
`ifdef GLYPH_ARB_RR_EN
   logic        m_last;
`endif
   logic [5:0]  e_rom;
   logic [55:0] e_glyph;
   logic        e_unk, e_ack0, e_ack1, e_busy;

   always #5 clk = ~clk;

   glyph_rom_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req0),
      .req1     (req1),
      .code0    (code0),
      .code1    (code1),
      .ack0     (ack0),
      .ack1     (ack1),
      .glyph    (glyph),
      .unk      (unk),
      .rom_code (rom_code),
      .rom_col0 (rom_q[7:0]),
      .rom_col1 (rom_q[15:8]),
      .rom_col2 (rom_q[23:16]),
      .rom_col3 (rom_q[31:24]),
      .rom_col4 (rom_q[39:32]),
      .rom_col5 (rom_q[47:40]),
      .rom_col6 (rom_q[55:48]),
      .busy     (busy)
   );

   // Glyph table, packed {col6..col0}.
   function automatic logic [55:0] glyph_of(input logic [5:0] c);
      logic [55:0] g;
      if (c == 6'h00)
         g = {8'h00, 8'h3E, 8'h45, 8'h49, 8'h51, 8'h3E, 8'h00};
      else if (c == 6'h01)
         g = {8'h00, 8'h00, 8'h40, 8'h7F, 8'h42, 8'h00, 8'h00};
      else if (c == 6'h24)
         g = {8'h03, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      else if (c >= 6'h25 && c <= 6'h3D)
         g = {8'h00, 8'h22, 8'h14, 8'h08, 8'h14, 8'h22, 8'h00};
      else if (c == 6'h3E)
         g = '0;
      else begin
         g = '0;
         for (int i = 0; i < 7; i++) g[i*8 +: 8] = {c, 2'(i)} ^ 8'hA5;
      end
      return g;
   endfunction

   // ROM answers one clock after it samples rom_code.
   always_ff @(posedge clk) rom_q <= glyph_of(rom_code);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_infl  = 1'b0;
      m_age   = 0;
      m_win   = 1'b0;
      m_code  = 6'h3E;
`ifdef GLYPH_ARB_RR_EN
      m_last  = 1'b1;
`endif
      e_rom   = 6'h3E;
      e_glyph = '0;
      e_unk   = 1'b0;
      e_ack0  = 1'b0;
      e_ack1  = 1'b0;
      e_busy  = 1'b0;
   endtask

   // One clock edge of the transaction timeline: grant at k, glyph at k+2, ack at k+3.
   task automatic model_step();
      logic w;
      if (rst) begin
         model_reset();
         return;
      end
      e_ack0 = 1'b0;
      e_ack1 = 1'b0;
      if (m_infl) begin
         m_age++;
         if (m_age == 2) begin
            e_glyph = glyph_of(m_code);
            e_unk   = (m_code >= 6'h25) && (m_code <= 6'h3D);
         end
         if (m_age == 3) begin
            e_ack0 = !m_win;
            e_ack1 = m_win;
            m_infl = 1'b0;
         end
      end else if (req0 || req1) begin
`ifdef GLYPH_ARB_RR_EN
         w = (req0 && req1) ? !m_last : !req0;
         m_last = w;
`else
         w = !req0;
`endif
         m_win  = w;
         m_code = w ? code1 : code0;
         e_rom  = m_code;
         m_infl = 1'b1;
         m_age  = 0;
      end
      e_busy = m_infl;
   endtask

   task automatic check_all();
      check("ack0", 64'(ack0), 64'(e_ack0));
      check("ack1", 64'(ack1), 64'(e_ack1));
      check("busy", 64'(busy), 64'(e_busy));
      check("rom_code", 64'(rom_code), 64'(e_rom));
      check("glyph", 64'(glyph), 64'(e_glyph));
      check("unk", 64'(unk), 64'(e_unk));
      if (ack0 || ack1)
         $display("txn: requester=%0d code=%02h glyph=%014h unk=%0b", ack1, rom_code, glyph, unk);
   endtask

   // Drive inputs for the coming edge, check at the falling edge, step the model at the rising edge.
   task automatic tick(input logic nrst, input logic nr0, input logic nr1,
                       input logic [5:0] nc0, input logic [5:0] nc1);
      logic was_rst;
      was_rst = rst;
      rst   = nrst;
      req0  = nr0;
      req1  = nr1;
      code0 = nc0;
      code1 = nc1;
      if (nrst && !was_rst) begin
         model_reset();
         #1;
         check("async_rst_busy", 64'(busy), 64'(0));
         check("async_rst_rom_code", 64'(rom_code), 64'(6'h3E));
         check("async_rst_ack", 64'({ack1, ack0}), 64'(0));
      end
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Request then idle until the ack edge has just passed.
   task automatic serve(input logic r0, input logic r1, input logic [5:0] c0, input logic [5:0] c1);
      tick(1'b0, r0, r1, c0, c1);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, c0, c1);
   endtask

   initial begin
      int gcnt;
      int gw [4];
      int h0, h1, rcnt;
      logic nr0, nr1;
      logic [5:0] c0, c1;

      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; code0 = '0; code1 = '0;
      model_reset();
      tick(1'b1, 1'b0, 1'b0, 6'h00, 6'h00);
      check("reset_glyph", 64'(glyph), 64'(0));
      check("reset_rom_code", 64'(rom_code), 64'(6'h3E));
      tick(1'b1, 1'b0, 1'b0, 6'h00, 6'h00);

      // "0" from requester 0
      serve(1'b1, 1'b0, 6'h00, 6'h00);
      check("t28_ack0", 64'(ack0), 64'(1));
      check("t28_ack1", 64'(ack1), 64'(0));
      check("t28_col1", 64'(glyph[15:8]), 64'(8'h3E));
      check("t28_col3", 64'(glyph[31:24]), 64'(8'h49));
      check("t28_unk", 64'(unk), 64'(0));
      tick(1'b0, 1'b0, 1'b0, 6'h00, 6'h00);

      // "/" from requester 1
      serve(1'b0, 1'b1, 6'h00, 6'h24);
      check("t29_ack1", 64'(ack1), 64'(1));
      check("t29_ack0", 64'(ack0), 64'(0));
      check("t29_glyph", 64'(glyph), 64'(56'h03040810204080));
      tick(1'b0, 1'b0, 1'b0, 6'h00, 6'h00);

      // unknown code renders as "*"
      serve(1'b1, 1'b0, 6'h30, 6'h00);
      check("t31_unk", 64'(unk), 64'(1));
      check("t31_col1", 64'(glyph[15:8]), 64'(8'h22));
      check("t31_col3", 64'(glyph[31:24]), 64'(8'h08));
      tick(1'b0, 1'b0, 1'b0, 6'h00, 6'h00);

      // code changes while busy are ignored
      tick(1'b0, 1'b1, 1'b0, 6'h01, 6'h00);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 6'h02, 6'h00);
      check("t33_ack0", 64'(ack0), 64'(1));
      check("t33_col3", 64'(glyph[31:24]), 64'(8'h7F));
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 6'h00, 6'h00);

      // reset during WAIT aborts, then a fresh request is served
      tick(1'b0, 1'b1, 1'b0, 6'h05, 6'h00);
      tick(1'b0, 1'b0, 1'b0, 6'h05, 6'h00);
      tick(1'b1, 1'b0, 1'b0, 6'h05, 6'h00);
      tick(1'b1, 1'b0, 1'b0, 6'h05, 6'h00);
      check("t32_no_ack", 64'({ack1, ack0}), 64'(0));
      serve(1'b1, 1'b0, 6'h00, 6'h00);
      check("t32_ack0", 64'(ack0), 64'(1));
      check("t32_col3", 64'(glyph[31:24]), 64'(8'h49));
      tick(1'b0, 1'b0, 1'b0, 6'h00, 6'h00);

      // both requesters held from a fresh reset
      tick(1'b1, 1'b0, 1'b0, 6'h0A, 6'h0B);
      tick(1'b1, 1'b0, 1'b0, 6'h0A, 6'h0B);
      gcnt = 0;
      for (int i = 0; i < 4; i++) gw[i] = 9;
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 1'b1, 1'b1, 6'h0A, 6'h0B);
         if ((ack0 || ack1) && gcnt < 4) begin
            gw[gcnt] = ack1 ? 1 : 0;
            gcnt++;
         end
      end
      for (int i = 0; i < 4; i++) begin
`ifdef GLYPH_ARB_RR_EN
         check("t30_rr_grant", 64'(gw[i]), 64'(i % 2));
`else
         check("t30_fixed_grant", 64'(gw[i]), 64'(0));
`endif
      end
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 6'h0A, 6'h0B);

      // random traffic with occasional resets
      h0 = 0; h1 = 0; rcnt = 0; nr0 = 1'b0; nr1 = 1'b0; c0 = '0; c1 = '0;
      for (int i = 0; i < 400; i++) begin
         if (rcnt > 0) rcnt--;
         else if ($urandom_range(0, 79) == 0) rcnt = 2;
         if (h0 == 0) begin
            if ($urandom_range(0, 1) == 1) begin
               if (!nr0) c0 = 6'($urandom_range(0, 63));
               nr0 = 1'b1;
            end else nr0 = 1'b0;
            h0 = $urandom_range(1, 8);
         end
         if (h1 == 0) begin
            if ($urandom_range(0, 1) == 1) begin
               if (!nr1) c1 = 6'($urandom_range(0, 63));
               nr1 = 1'b1;
            end else nr1 = 1'b0;
            h1 = $urandom_range(1, 8);
         end
         h0--;
         h1--;
         tick(rcnt > 0, nr0, nr1, c0, c1);
      end
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0, 6'h00, 6'h00);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/glyph_rom_arbiter.md
GLYPH_ROM_ARBITER -- requirements
Module: glyph_rom_arbiter

Interface
REQ-001 The block SHALL have the input clk, 1 bit, as the system clock; all state changes on the rising edge.
REQ-002 The block SHALL have the input rst, 1 bit, as an asynchronous, active-high reset.
REQ-003 The block SHALL have the inputs req0 and req1, 1 bit each, as request lines for requester 0 and requester 1.
REQ-004 The block SHALL have the inputs code0 and code1, 6 bits each, as the character code for each requester; each code is held stable while its req is high.
REQ-005 The block SHALL have the outputs ack0 and ack1, 1 bit each: a one-cycle completion pulse per requester.
REQ-006 The block SHALL have the output glyph, 56 bits: the captured glyph as {col6,...,col0}, 8 bits per column.
REQ-007 The block SHALL have the output unk, 1 bit, set when the served code has no dedicated glyph (codes 0x25-0x3D).
REQ-008 The block SHALL have the output rom_code, 6 bits: a registered code driven to the shared glyph ROM.
REQ-009 The block SHALL have the inputs rom_col0 to rom_col6, 8 bits each: ROM columns, registered by the ROM one clock after rom_code.
REQ-010 The block SHALL have the output busy, 1 bit, high in every state except IDLE.

Function
REQ-011 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP, with busy = (state != IDLE).
REQ-012 In IDLE with at least one req high, the arbiter SHALL select a winner at the edge, load rom_code from the winner's code, record the winner ID, and go to ISSUE.
REQ-013 In IDLE with no req high, the block SHALL stay in IDLE, and rom_code SHALL hold its value.
REQ-014 ISSUE SHALL go to WAIT unconditionally; this is the edge at which the ROM samples rom_code.
REQ-015 WAIT SHALL go to RESP and latch glyph <= {rom_col6..rom_col0} and unk <= (rom_code in 0x25..0x3D).
REQ-016 In RESP, the ack of the recorded winner SHALL be high for exactly one cycle, and the other ack SHALL stay low; the next state is IDLE.
REQ-017 Latency SHALL be: req sampled at edge k gives ack high in the cycle after edge k+3, and glyph valid from that cycle.
REQ-018 glyph and unk SHALL hold their values until the next WAIT->RESP transition.
REQ-019 Peak throughput SHALL be one grant per 4 cycles.
REQ-020 A requester drops req in the cycle after ack; a req still high at the next IDLE sample SHALL be treated as a new request.
REQ-021 Requests arriving while busy SHALL be ignored until IDLE, and code changes while busy SHALL have no effect on the current transaction.
REQ-022 With a single requester active, that requester SHALL be granted regardless of arbitration mode.

Reset
REQ-023 On rst, the block SHALL asynchronously set state=IDLE, ack0=ack1=0, glyph=0, unk=0, rom_code=6'h3E (space), busy=0, and the round-robin pointer to favour requester 0.
REQ-024 A reset during ISSUE, WAIT or RESP SHALL abort the transaction with no ack, and both requesters SHALL re-request after reset.
REQ-025 The first arbitration after reset release SHALL occur at the first rising edge on which rst is low.

Configuration
REQ-026 With macro GLYPH_ARB_RR_EN defined, simultaneous requests SHALL be served round-robin: the winner is the requester not granted last, and the pointer updates on each grant.
REQ-027 With GLYPH_ARB_RR_EN undefined, arbitration SHALL be fixed priority with requester 0 always winning ties, and no pointer register SHALL exist.

Verification
REQ-028 The bench SHALL cover: req0=1, code0=0x00 from IDLE -> ack0 pulse 4 edges later, glyph col1=0x3E, col3=0x49, unk=0, ack1=0.
REQ-029 The bench SHALL cover: req1=1, code1=0x24 ("/") -> ack1 pulse, glyph={0x03,0x04,0x08,0x10,0x20,0x40,0x80} for col6..col0.
REQ-030 The bench SHALL cover: req0 and req1 both held, codes 0x0A/0x0B, RR build -> grants alternate 0,1,0,1; fixed build -> req0 is always granted and req1 starves.
REQ-031 The bench SHALL cover: code0=0x30 -> unk=1 and glyph = "*" pattern (col1=0x22, col3=0x08).
REQ-032 The bench SHALL cover: rst asserted in WAIT -> no ack, busy=0 and rom_code=0x3E immediately; after release, a req0 is served normally.
REQ-033 The bench SHALL cover: code0 changed from 0x01 to 0x02 during ISSUE -> the glyph returned is "1" (col3=0x7F).
